// File: rtl/chess_clock_controller.sv
// Two-player chess clock: BCD countdown per player, turn hand-over, sticky timeout flags.
// Latency: state, time and turn updates are registered one edge after tick/turnEnd.
// No backpressure: inputs are levels or single-cycle pulses, outputs are always valid.
module chess_clock_controller #(
   parameter int CLOCK_FREQ = 50000000,
   parameter int START_MINS = 5
) (
   input  logic       clock,
   input  logic       globalReset,
   input  logic       StartStopSwitch,
   input  logic       TimerSwitch,
   input  logic       turnEnd,
   output logic [3:0] whiteMins,
   output logic [3:0] whiteTensSec,
   output logic [3:0] whiteUnitsSec,
   output logic [3:0] blackMins,
   output logic [3:0] blackTensSec,
   output logic [3:0] blackUnitsSec,
   output logic       activePlayer,
   output logic       running,
   output logic       whiteFlag,
   output logic       blackFlag
);

   localparam int PW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
   localparam logic [PW-1:0] PMAX = PW'(CLOCK_FREQ - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, TIMEOUT} state_t;

   typedef struct packed {
      logic [3:0] mins;
      logic [3:0] tens;
      logic [3:0] units;
   } bcd_time_t;

   localparam bcd_time_t START_TIME = '{mins: 4'(START_MINS), tens: 4'd0, units: 4'd0};
   localparam bcd_time_t ZERO_TIME  = '0;

   state_t    state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   bcd_time_t white_q, white_d, black_q, black_d;
   logic      active_q, active_d;
   logic      wflag_q, wflag_d, bflag_q, bflag_d;

   logic      tick;
   bcd_time_t act_dec;
   logic      expired;

   // One-second BCD decrement with borrows; callers never pass 0:00.
   function automatic bcd_time_t dec_time(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.units != 4'd0) begin
         r.units = t.units - 4'd1;
      end else begin
         r.units = 4'd9;
         if (t.tens != 4'd0) begin
            r.tens = t.tens - 4'd1;
         end else begin
            r.tens = 4'd5;
            if (t.mins != 4'd0) r.mins = t.mins - 4'd1;
         end
      end
      return r;
   endfunction

   // Tick only counts in timed RUN; the decrement always targets the player to move.
   assign tick    = (state_q == RUN) && TimerSwitch && (presc_q == PMAX);
   assign act_dec = dec_time(active_q ? black_q : white_q);
   assign expired = tick && (act_dec == ZERO_TIME);

   // Next-state logic: FSM, prescaler, player clocks, turn and flags.
   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      white_d  = white_q;
      black_d  = black_q;
      active_d = active_q;
      wflag_d  = wflag_q;
      bflag_d  = bflag_q;
      case (state_q)
         IDLE: begin
            presc_d = '0;
            if (StartStopSwitch) state_d = RUN;
         end
         RUN: begin
            if (!StartStopSwitch) state_d = PAUSE;
            // A new turn always starts with a full second; untimed play freezes the count.
            if (turnEnd)          presc_d = '0;
            else if (TimerSwitch) presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
            if (tick) begin
               if (active_q) black_d = act_dec;
               else          white_d = act_dec;
            end
            // Reaching 0:00 wins over both the pause request and the turn hand-over.
            if (expired) begin
               state_d = TIMEOUT;
               presc_d = '0;
               if (active_q) bflag_d = 1'b1;
               else          wflag_d = 1'b1;
            end else if (turnEnd) begin
               active_d = ~active_q;
            end
         end
         PAUSE: begin
            if (StartStopSwitch) state_d = RUN;
         end
         TIMEOUT: begin
            presc_d = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with asynchronous return to the start-of-game position.
   always_ff @(posedge clock or negedge globalReset) begin
      if (!globalReset) begin
         state_q  <= IDLE;
         presc_q  <= '0;
         white_q  <= START_TIME;
         black_q  <= START_TIME;
         active_q <= 1'b0;
         wflag_q  <= 1'b0;
         bflag_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         white_q  <= white_d;
         black_q  <= black_d;
         active_q <= active_d;
         wflag_q  <= wflag_d;
         bflag_q  <= bflag_d;
      end
   end

   assign whiteMins     = white_q.mins;
   assign whiteTensSec  = white_q.tens;
   assign whiteUnitsSec = white_q.units;
   assign blackMins     = black_q.mins;
   assign blackTensSec  = black_q.tens;
   assign blackUnitsSec = black_q.units;
   assign activePlayer  = active_q;
   assign running       = (state_q == RUN);
   assign whiteFlag     = wflag_q;
   assign blackFlag     = bflag_q;

endmodule

// File: tb/tb_chess_clock_controller.sv
// Directed bench for chess_clock_controller with a 4-cycle second and 1-minute games.
// Latency: expected values are hand-derived per clock edge; checks sample at the falling edge.
// No backpressure: stimulus is driven on the falling edge, away from the active edge.
module tb_chess_clock_controller;

   logic       clock;
   logic       globalReset;
   logic       StartStopSwitch;
   logic       TimerSwitch;
   logic       turnEnd;
   logic [3:0] whiteMins, whiteTensSec, whiteUnitsSec;
   logic [3:0] blackMins, blackTensSec, blackUnitsSec;
   logic       activePlayer, running, whiteFlag, blackFlag;

   int checks = 0;
   int fails  = 0;

   chess_clock_controller #(
      .CLOCK_FREQ(4),
      .START_MINS(1)
   ) dut (
      .clock          (clock),
      .globalReset    (globalReset),
      .StartStopSwitch(StartStopSwitch),
      .TimerSwitch    (TimerSwitch),
      .turnEnd        (turnEnd),
      .whiteMins      (whiteMins),
      .whiteTensSec   (whiteTensSec),
      .whiteUnitsSec  (whiteUnitsSec),
      .blackMins      (blackMins),
      .blackTensSec   (blackTensSec),
      .blackUnitsSec  (blackUnitsSec),
      .activePlayer   (activePlayer),
      .running        (running),
      .whiteFlag      (whiteFlag),
      .blackFlag      (blackFlag)
   );

   logic [11:0] white, black;
   assign white = {whiteMins, whiteTensSec, whiteUnitsSec};
   assign black = {blackMins, blackTensSec, blackUnitsSec};

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Each call advances exactly n rising edges and returns at a falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_white"},   32'(white), 32'h100);
      chk({tag, "_black"},   32'(black), 32'h100);
      chk({tag, "_active"},  32'(activePlayer), 32'd0);
      chk({tag, "_running"}, 32'(running), 32'd0);
      chk({tag, "_flags"},   32'({whiteFlag, blackFlag}), 32'd0);
   endtask

   initial begin
      globalReset     = 1'b0;
      StartStopSwitch = 1'b0;
      TimerSwitch     = 1'b1;
      turnEnd         = 1'b0;
      step(2);
      chk_reset_values("reset");

      // Start: RUN after one edge, first tick four edges later on white.
      globalReset     = 1'b1;
      StartStopSwitch = 1'b1;
      step(1);
      chk("start_running", 32'(running), 32'd1);
      step(3);
      chk("pre_tick_white", 32'(white), 32'h100);
      step(1);
      chk("tick_white", 32'(white), 32'h059);
      chk("tick_black_hold", 32'(black), 32'h100);

      // Turn end with the prescaler at 2 hands over and restarts the second.
      step(2);
      turnEnd = 1'b1;
      step(1);
      turnEnd = 1'b0;
      chk("turn_active", 32'(activePlayer), 32'd1);
      chk("turn_white_hold", 32'(white), 32'h059);
      step(3);
      chk("black_pre_tick", 32'(black), 32'h100);
      step(1);
      chk("black_tick", 32'(black), 32'h059);
      chk("black_tick_white", 32'(white), 32'h059);

      // Pause mid-second: prescaler advances to 3 on the switch-off edge, then holds.
      step(2);
      StartStopSwitch = 1'b0;
      step(1);
      chk("pause_running", 32'(running), 32'd0);
      step(20);
      chk("pause_black_hold", 32'(black), 32'h059);
      chk("pause_white_hold", 32'(white), 32'h059);
      StartStopSwitch = 1'b1;
      step(1);
      chk("resume_running", 32'(running), 32'd1);
      chk("resume_no_tick", 32'(black), 32'h059);
      step(1);
      chk("resume_tick", 32'(black), 32'h058);

      // Back to white, count down to 0:10.
      turnEnd = 1'b1;
      step(1);
      turnEnd = 1'b0;
      chk("to_white", 32'(activePlayer), 32'd0);
      step(196);
      chk("white_010", 32'(white), 32'h010);
      chk("white_010_black", 32'(black), 32'h058);

      // Tick and turn end together: decrement white, then hand over.
      step(3);
      turnEnd = 1'b1;
      step(1);
      turnEnd = 1'b0;
      chk("coinc_white", 32'(white), 32'h009);
      chk("coinc_active", 32'(activePlayer), 32'd1);
      chk("coinc_black", 32'(black), 32'h058);

      // White again, run to 0:01, then final tick coincident with turn end.
      turnEnd = 1'b1;
      step(1);
      turnEnd = 1'b0;
      step(32);
      chk("white_001", 32'(white), 32'h001);
      chk("white_001_flag", 32'(whiteFlag), 32'd0);
      step(3);
      turnEnd = 1'b1;
      step(1);
      turnEnd = 1'b0;
      chk("timeout_white", 32'(white), 32'h000);
      chk("timeout_wflag", 32'(whiteFlag), 32'd1);
      chk("timeout_running", 32'(running), 32'd0);
      chk("timeout_no_toggle", 32'(activePlayer), 32'd0);

      // Timeout is sticky against turn ends and switch toggles.
      turnEnd = 1'b1;
      step(1);
      turnEnd = 1'b0;
      StartStopSwitch = 1'b0;
      step(2);
      StartStopSwitch = 1'b1;
      step(6);
      chk("sticky_running", 32'(running), 32'd0);
      chk("sticky_active", 32'(activePlayer), 32'd0);
      chk("sticky_white", 32'(white), 32'h000);
      chk("sticky_black", 32'(black), 32'h058);
      chk("sticky_flags", 32'({whiteFlag, blackFlag}), 32'b10);

      // Asynchronous reset out of TIMEOUT, between clock edges.
      #2 globalReset = 1'b0;
      #1 chk_reset_values("async_reset1");

      // Untimed game: turns alternate, digits never move.
      @(negedge clock);
      globalReset = 1'b1;
      TimerSwitch = 1'b0;
      step(1);
      chk("untimed_running", 32'(running), 32'd1);
      for (int i = 1; i <= 3; i++) begin
         turnEnd = 1'b1;
         step(1);
         turnEnd = 1'b0;
         chk("untimed_active", 32'(activePlayer), 32'(i % 2));
         step(5);
         chk("untimed_white", 32'(white), 32'h100);
         chk("untimed_black", 32'(black), 32'h100);
      end

      // Reset mid-RUN with black to move, then re-enter RUN one edge after release.
      #2 globalReset = 1'b0;
      #1 chk_reset_values("async_reset2");
      @(negedge clock);
      globalReset = 1'b1;
      step(1);
      chk("rerun_running", 32'(running), 32'd1);
      chk("rerun_active", 32'(activePlayer), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
